// File: rtl/wb_sram_pkg.sv
// rtl/wb_sram_pkg.sv - shared FSM encoding and wait-state limits for wb_sram_ctrl
package wb_sram_pkg;

    typedef logic [1:0] wb_state_t;

    localparam wb_state_t ST_IDLE = 2'd0;
    localparam wb_state_t ST_WAIT = 2'd1;
    localparam wb_state_t ST_ACK  = 2'd2;
    localparam wb_state_t ST_ERR  = 2'd3;

    // Largest supported WAIT_ST; larger values are clamped to this.
    localparam int WAIT_ST_MAX = 7;

    // Wide enough for WAIT_ST_MAX plus the optional read-register cycle.
    localparam int WAIT_CNT_W = 4;

    // Number of byte-address bits below the word index.
    function automatic int lane_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/wb_sram_mem.sv
// rtl/wb_sram_mem.sv - single-port synchronous-read byte-write RAM, DW x DEPTH
module wb_sram_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    parameter int AWM   = $clog2(DEPTH)
) (
    input  logic            sys_clk,
    input  logic            en,
    input  logic            we,
    input  logic [AWM-1:0]  addr,
    input  logic [DW/8-1:0] sel,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    // One access per cycle: byte-lane write, or registered read that holds until the next read.
    always_ff @(posedge sys_clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DW / 8; b++) begin
                    if (sel[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wb_sram_ctrl.sv
// rtl/wb_sram_ctrl.sv - Wishbone slave SRAM controller; WB_SRAM_RDREG_EN adds a read output register
module wb_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int DEPTH   = 512,
    parameter int WAIT_ST = 0
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [AW-1:0]   wbs_adr_i,
    input  logic [DW/8-1:0] wbs_sel_i,
    input  logic [DW-1:0]   wbs_dat_i,
    output logic [DW-1:0]   wbs_dat_o,
    output logic            wbs_ack_o,
    output logic            wbs_err_o,
    output logic            busy_o
);

    localparam int LSB      = lane_shift(DW);
    localparam int AWM      = $clog2(DEPTH);
    localparam int WAIT_EFF = (WAIT_ST > WAIT_ST_MAX) ? WAIT_ST_MAX : WAIT_ST;
`ifdef WB_SRAM_RDREG_EN
    localparam int RD_EXTRA = 1;
`else
    localparam int RD_EXTRA = 0;
`endif
    localparam logic [WAIT_CNT_W-1:0] TGT_WR  = WAIT_CNT_W'(WAIT_EFF);
    localparam logic [WAIT_CNT_W-1:0] TGT_RD  = WAIT_CNT_W'(WAIT_EFF + RD_EXTRA);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);

    wb_state_t             state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  we_q;
    logic [DW/8-1:0]       sel_q;
    logic [DW-1:0]         wdat_q;
    logic [AWM-1:0]        idx_q;

    logic [AW-1:0]         idx_full;
    logic                  in_range;
    logic                  accept;
    logic [WAIT_CNT_W-1:0] tgt_in;
    logic [WAIT_CNT_W-1:0] tgt_q;
    logic                  ram_re;
    logic                  ram_we;
    logic [AWM-1:0]        ram_addr;
    logic [DW-1:0]         ram_rdata;

    assign idx_full = wbs_adr_i >> LSB;
    assign in_range = (64'(idx_full) < 64'(DEPTH));
    assign accept   = (state == ST_IDLE) && wbs_cyc_i && wbs_stb_i;
    // Reads with the output register need one extra cycle before ack.
    assign tgt_in   = wbs_we_i ? TGT_WR : TGT_RD;
    assign tgt_q    = we_q ? TGT_WR : TGT_RD;

    // RAM is read directly from the bus in C0 and written from latched state in the ack cycle.
    assign ram_re   = accept && in_range && !wbs_we_i;
    assign ram_we   = (state == ST_ACK) && we_q;
    assign ram_addr = (state == ST_IDLE) ? idx_full[AWM-1:0] : idx_q;

    assign wbs_ack_o = (state == ST_ACK);
    assign wbs_err_o = (state == ST_ERR);
    assign busy_o    = (state != ST_IDLE);

    // Transfer FSM: accept in IDLE, optionally count wait states, then one ack or err cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (accept) begin
                        if (!in_range) begin
                            state <= ST_ERR;
                        end else if (tgt_in == '0) begin
                            state <= ST_ACK;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == tgt_q - CNT_ONE) begin
                        state    <= ST_ACK;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the request in C0 so the bus may change while the transfer completes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            sel_q  <= '0;
            wdat_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            wdat_q <= wbs_dat_i;
            idx_q  <= idx_full[AWM-1:0];
        end
    end

    wb_sram_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AWM   (AWM)
    ) u_mem (
        .sys_clk (sys_clk),
        .en      (ram_re || ram_we),
        .we      (ram_we),
        .addr    (ram_addr),
        .sel     (sel_q),
        .wdata   (wdat_q),
        .rdata   (ram_rdata)
    );

`ifdef WB_SRAM_RDREG_EN
    logic [DW-1:0] rd_q;

    // Output register: loaded from the RAM during the read's wait phase, cleared on error or reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (accept && !in_range) begin
            rd_q <= '0;
        end else if ((state == ST_WAIT) && !we_q) begin
            rd_q <= ram_rdata;
        end
    end

    assign wbs_dat_o = rd_q;
`else
    logic dat_src;

    // The RAM output register already holds the last read; this flag masks it to zero after reset or error.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_src <= 1'b0;
        end else if (accept && !in_range) begin
            dat_src <= 1'b0;
        end else if (ram_re) begin
            dat_src <= 1'b1;
        end
    end

    assign wbs_dat_o = dat_src ? ram_rdata : '0;
`endif

endmodule

// File: doc/wb_sram_ctrl.md
WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

Interface
REQ-001 Parameter DW, default 32, data width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter AW, default 32, Wishbone byte-address width.
REQ-003 Parameter DEPTH, default 512, number of DW-bit words; any value 2..65536, not necessarily a power of two.
REQ-004 Parameter WAIT_ST, default 0, extra wait cycles before ack; range 0..7.
REQ-005 sys_clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 wbs_cyc_i  input  1  bus cycle valid.
REQ-008 wbs_stb_i  input  1  transfer strobe.
REQ-009 wbs_we_i  input  1  1 = write, 0 = read.
REQ-010 wbs_adr_i  input  AW  byte address.
REQ-011 wbs_sel_i  input  DW/8  byte-lane enables.
REQ-012 wbs_dat_i  input  DW  write data.
REQ-013 wbs_dat_o  output  DW  read data.
REQ-014 wbs_ack_o  output  1  transfer-complete pulse.
REQ-015 wbs_err_o  output  1  transfer-error pulse.
REQ-016 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Word index SHALL be wbs_adr_i >> log2(DW/8); low address bits are ignored.
REQ-018 The FSM SHALL have states IDLE, WAIT, ACK, ERR.
REQ-019 IDLE: when cyc&stb=1, the FSM SHALL latch we, sel, data and index in that cycle (C0), then move as follows:
- index >= DEPTH: go to ERR.
- WAIT_ST=0: go to ACK.
- otherwise: go to WAIT.
REQ-020 WAIT SHALL count WAIT_ST cycles, then go to ACK.
REQ-021 For a read, the RAM SHALL be read in C0 and the data held stable from C1 until ack.
REQ-022 Ack timing: wbs_ack_o SHALL be high for exactly one cycle, in C1+WAIT_ST.
REQ-023 Write commit: a write SHALL update only the byte lanes with sel=1, in the ack cycle only.
REQ-024 ERR: wbs_err_o SHALL pulse for one cycle in C1, with no memory write and wbs_dat_o = 0.
REQ-025 After ACK or ERR the FSM SHALL return to IDLE; a new request SHALL NOT be accepted earlier than the following cycle.
REQ-026 wbs_ack_o and wbs_err_o SHALL never be high together.
REQ-027 Abort: if wbs_cyc_i drops in WAIT, the FSM SHALL return to IDLE with no ack, no err and no write.
REQ-028 sel=0 on a write SHALL still ack, and memory SHALL remain unchanged.
REQ-029 wbs_dat_o SHALL hold its last read value between transfers.

Reset
REQ-030 While rst_n=0 the block SHALL hold:
- FSM in IDLE
- ack, err and busy_o = 0
- wbs_dat_o = 0
- wait counter = 0
REQ-031 Reset during WAIT or ACK SHALL abandon the transfer without a write; RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With macro WB_SRAM_RDREG_EN defined, reads SHALL pass through an extra output register: read ack in C2+WAIT_ST, write latency unchanged.
REQ-033 Without WB_SRAM_RDREG_EN, read and write ack SHALL both occur in C1+WAIT_ST.

Structure
REQ-034 FSM state encoding and the WAIT_ST range limit SHALL reside in a shared package, wb_sram_pkg.
REQ-035 The storage array SHALL be a sub-module, wb_sram_mem: single-port, synchronous read, byte-write, DW x DEPTH, inferrable as block RAM.

Verification
REQ-036 Bench SHALL cover: DW=32, WAIT_ST=0, write 0xDEADBEEF to 0x10 with sel=0xF, then read 0x10 -> ack in C1 for each, read returns 0xDEADBEEF.
REQ-037 Bench SHALL cover: write 0x11223344 to 0x20 with sel=0x5 over prior 0xAAAAAAAA -> read returns 0xAA22AA44.
REQ-038 Bench SHALL cover: DEPTH=512, read from byte address 0x800 -> err pulse in C1, no ack, dat_o = 0, memory unchanged.
REQ-039 Bench SHALL cover: WAIT_ST=3, cyc dropped in the second WAIT cycle of a write -> no ack, no err, FSM in IDLE next cycle, target word unchanged.
REQ-040 Bench SHALL cover: WB_SRAM_RDREG_EN defined, WAIT_ST=2, read -> ack in C4, write -> ack in C3.
REQ-041 Bench SHALL cover: rst_n asserted in the ack cycle of a write to 0x30 -> ack=0 immediately, word at 0x30 unchanged, busy_o=0.
